openfire_mem_ctrl: RTL and testbench

OPENFIRE_MEM_CTRL -- requirements
Module: openfire_mem_ctrl

---
 rtl/openfire_mem_ctrl_pkg.sv | 28 ++
 rtl/openfire_mem_lane.sv | 39 +++
 rtl/openfire_mem_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_openfire_mem_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/openfire_mem_ctrl_pkg.sv
// Shared types and constants for the OpenFire SRAM controller.
package openfire_mem_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LATCH  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic PORT_DMEM = 1'b0;
    localparam logic PORT_IMEM = 1'b1;

    // Size codes 2 and 3 both mean a full word.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/openfire_mem_lane.sv
// Big-endian lane logic: store replication/byte enables and load steering.
module openfire_mem_lane
    import openfire_mem_ctrl_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic [1:0]        offset_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [BE_W-1:0]   be_c_o,
    output logic [DATA_W-1:0] wdata_c_o,
    output logic [DATA_W-1:0] rdata_c_o,
    output logic              misaligned_c_o
);

    always_comb begin
        be_c_o         = 4'b1111;
        wdata_c_o      = wdata_i;
        rdata_c_o      = rdata_i;
        misaligned_c_o = 1'b0;
        if (is_word(size_i)) begin
            misaligned_c_o = (offset_i != 2'b00);
        end else if (size_i == SZ_HALF) begin
            misaligned_c_o = offset_i[0];
            wdata_c_o      = {2{wdata_i[15:0]}};
            be_c_o         = offset_i[1] ? 4'b0011 : 4'b1100;
            rdata_c_o      = {16'h0, (offset_i[1] ? rdata_i[15:0] : rdata_i[31:16])};
        end else begin
            wdata_c_o = {4{wdata_i[7:0]}};
            be_c_o    = 4'b1000 >> offset_i;
            case (offset_i)
                2'd0:    rdata_c_o = {24'h0, rdata_i[31:24]};
                2'd1:    rdata_c_o = {24'h0, rdata_i[23:16]};
                2'd2:    rdata_c_o = {24'h0, rdata_i[15:8]};
                default: rdata_c_o = {24'h0, rdata_i[7:0]};
            endcase
        end
    end

endmodule

// File: rtl/openfire_mem_ctrl.sv
// Two-port (instruction/data) arbiter and sequencer for a single-ported SRAM.
module openfire_mem_ctrl
    import openfire_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       imem_addr,
    input  logic              imem_re,
    output logic [31:0]       imem_data_in,
    output logic              imem_done,
    input  logic [31:0]       dmem_addr,
    input  logic [31:0]       dmem_data_out,
    input  logic              dmem_re,
    input  logic              dmem_we,
    input  logic [1:0]        dmem_input_sel,
    output logic [31:0]       dmem_data_in,
    output logic              dmem_done,
    output logic              dmem_alignment_exception,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES - 1);

    state_e              state_q, state_d;
    logic                port_q, port_d;
    logic [1:0]          off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                write_q, write_d;
    logic                misal_q, misal_d;
    logic                prio_dmem_q, prio_dmem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                imem_done_q, imem_done_d;
    logic                dmem_done_q, dmem_done_d;
    logic                exc_q, exc_d;
    logic [DATA_W-1:0]   imem_data_q, imem_data_d;
    logic [DATA_W-1:0]   dmem_data_q, dmem_data_d;

    logic                dmem_req_c, grant_dmem_c, in_idle_c;
    logic [31:0]         req_addr_c;
    logic [1:0]          req_size_c, lane_size_c, lane_off_c;
    logic                req_write_c;
    logic [BE_W-1:0]     lane_be_c;
    logic [DATA_W-1:0]   lane_wdata_c, lane_rdata_c;
    logic                lane_misal_c, misal_c;
    logic                unused_addr_c;

    // Round-robin grant: a lone requester wins, otherwise the priority flag decides.
    assign dmem_req_c   = dmem_re | dmem_we;
    assign grant_dmem_c = dmem_req_c & (~imem_re | prio_dmem_q);
    assign req_addr_c   = grant_dmem_c ? dmem_addr : imem_addr;
    assign req_size_c   = grant_dmem_c ? dmem_input_sel : SZ_WORD;
    assign req_write_c  = grant_dmem_c & dmem_we;
    assign in_idle_c    = (state_q == ST_IDLE);
    assign lane_size_c  = in_idle_c ? req_size_c : size_q;
    assign lane_off_c   = in_idle_c ? req_addr_c[1:0] : off_q;
    assign misal_c      = lane_misal_c & grant_dmem_c;
    assign unused_addr_c = ^{imem_addr, dmem_addr};

    openfire_mem_lane u_lane (
        .size_i         (lane_size_c),
        .offset_i       (lane_off_c),
        .wdata_i        (dmem_data_out),
        .rdata_i        (mem_rdata),
        .be_c_o         (lane_be_c),
        .wdata_c_o      (lane_wdata_c),
        .rdata_c_o      (lane_rdata_c),
        .misaligned_c_o (lane_misal_c)
    );

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        off_d       = off_q;
        size_d      = size_q;
        write_d     = write_q;
        misal_d     = misal_q;
        prio_dmem_d = prio_dmem_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        imem_done_d = 1'b0;
        dmem_done_d = 1'b0;
        exc_d       = 1'b0;
        imem_data_d = imem_data_q;
        dmem_data_d = dmem_data_q;
        case (state_q)
            ST_IDLE: begin
                if (dmem_req_c || imem_re) begin
                    port_d      = grant_dmem_c ? PORT_DMEM : PORT_IMEM;
                    off_d       = req_addr_c[1:0];
                    size_d      = req_size_c;
                    write_d     = req_write_c;
                    misal_d     = misal_c;
                    prio_dmem_d = ~grant_dmem_c;
                    if (misal_c) begin
                        state_d = ST_LATCH;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_write_c;
                        mem_addr_d  = req_addr_c[ADDR_W+1:2];
                        mem_be_d    = lane_be_c;
                        mem_wdata_d = lane_wdata_c;
                    end
                end
            end
            ST_ACCESS: begin
                if (WAIT_STATES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = ST_LATCH;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_LATCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LATCH: begin
                state_d = ST_DONE;
                if (port_q == PORT_DMEM) begin
                    dmem_done_d = 1'b1;
                    exc_d       = misal_q;
                    if (!write_q && !misal_q) dmem_data_d = lane_rdata_c;
                end else begin
                    imem_done_d = 1'b1;
                    imem_data_d = lane_rdata_c;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            port_q      <= PORT_DMEM;
            off_q       <= '0;
            size_q      <= SZ_WORD;
            write_q     <= 1'b0;
            misal_q     <= 1'b0;
            prio_dmem_q <= 1'b1;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
            exc_q       <= 1'b0;
            imem_data_q <= '0;
            dmem_data_q <= '0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            off_q       <= off_d;
            size_q      <= size_d;
            write_q     <= write_d;
            misal_q     <= misal_d;
            prio_dmem_q <= prio_dmem_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
            exc_q       <= exc_d;
            imem_data_q <= imem_data_d;
            dmem_data_q <= dmem_data_d;
        end
    end

    assign imem_data_in             = imem_data_q;
    assign imem_done                = imem_done_q;
    assign dmem_data_in             = dmem_data_q;
    assign dmem_done                = dmem_done_q;
    assign dmem_alignment_exception = exc_q;
    assign mem_en                   = mem_en_q;
    assign mem_we                   = mem_we_q;
    assign mem_addr                 = mem_addr_q;
    assign mem_be                   = mem_be_q;
    assign mem_wdata                = mem_wdata_q;

endmodule

// File: tb/tb_openfire_mem_ctrl.sv
// Scoreboard bench for openfire_mem_ctrl with a behavioural SRAM.
module tb_openfire_mem_ctrl;

    localparam int unsigned WS  = 3;
    localparam int          LAT = 2 + WS;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr = '0;
    logic        imem_re = 1'b0;
    logic [31:0] imem_data_in;
    logic        imem_done;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_data_out = '0;
    logic        dmem_re = 1'b0;
    logic        dmem_we = 1'b0;
    logic [1:0]  dmem_input_sel = '0;
    logic [31:0] dmem_data_in;
    logic        dmem_done;
    logic        dmem_alignment_exception;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    openfire_mem_ctrl #(.ADDR_W(12), .WAIT_STATES(WS)) u_dut (
        .clock                    (clock),
        .reset                    (reset),
        .imem_addr                (imem_addr),
        .imem_re                  (imem_re),
        .imem_data_in             (imem_data_in),
        .imem_done                (imem_done),
        .dmem_addr                (dmem_addr),
        .dmem_data_out            (dmem_data_out),
        .dmem_re                  (dmem_re),
        .dmem_we                  (dmem_we),
        .dmem_input_sel           (dmem_input_sel),
        .dmem_data_in             (dmem_data_in),
        .dmem_done                (dmem_done),
        .dmem_alignment_exception (dmem_alignment_exception),
        .mem_en                   (mem_en),
        .mem_we                   (mem_we),
        .mem_addr                 (mem_addr),
        .mem_be                   (mem_be),
        .mem_wdata                (mem_wdata),
        .mem_rdata                (mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct { logic we; logic [3:0] be; logic [11:0] addr; logic [31:0] wdata; int pe; } sram_exp_t;
    typedef struct { logic [31:0] data; logic exc; int pe; } done_exp_t;

    sram_exp_t   sq[$];
    done_exp_t   dq[$];
    done_exp_t   iq[$];
    sram_exp_t   se;
    done_exp_t   de;
    int          tests = 0;
    int          failed = 0;
    int          pe = 0;
    logic [31:0] last_d = '0;
    logic        preload = 1'b1;
    logic [31:0] sram [256];

    always @(posedge clock) pe <= pe + 1;

    // SRAM: registered read data held until the next enable.
    always @(posedge clock) begin
        if (preload) begin
            sram[4] <= 32'hDEADBEEF;
            sram[8] <= 32'h01020304;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[7:0]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        failed++;
        $display("FAIL %s @%0t: output with no expected entry", name, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents an SRAM access or a done pulse.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_en) begin
                if (sq.size() == 0) unexpected("mem_en");
                else begin
                    se = sq.pop_front();
                    check("mem_we", 32'(mem_we), 32'(se.we));
                    check("mem_addr", 32'(mem_addr), 32'(se.addr));
                    check("mem_en_cycle", pe, se.pe);
                    if (se.we) begin
                        check("mem_be", 32'(mem_be), 32'(se.be));
                        check("mem_wdata", mem_wdata, se.wdata);
                    end
                end
            end
            if (dmem_done) begin
                if (dq.size() == 0) unexpected("dmem_done");
                else begin
                    de = dq.pop_front();
                    check("dmem_data_in", dmem_data_in, de.data);
                    check("dmem_exc", 32'(dmem_alignment_exception), 32'(de.exc));
                    check("dmem_done_cycle", pe, de.pe);
                end
            end else if (dmem_alignment_exception) begin
                unexpected("exception_without_done");
            end
            if (imem_done) begin
                if (iq.size() == 0) unexpected("imem_done");
                else begin
                    de = iq.pop_front();
                    check("imem_data_in", imem_data_in, de.data);
                    check("imem_done_cycle", pe, de.pe);
                end
            end
        end
    end

    task automatic push_d(input logic [31:0] addr, input logic [1:0] sel, input logic we,
                          input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd,
                          input int acc);
        logic        exc;
        logic [31:0] d;
        exc = (sel == 2'd1 && addr[0]) || (sel[1] && addr[1:0] != 2'b00);
        if (!exc) sq.push_back('{we, be, addr[13:2], wd, acc});
        d = (we || exc) ? last_d : rd;
        last_d = d;
        dq.push_back('{d, exc, acc + (exc ? 1 : LAT)});
    endtask

    task automatic push_i(input logic [31:0] addr, input logic [31:0] rd, input int acc);
        sq.push_back('{1'b0, 4'hF, addr[13:2], 32'h0, acc});
        iq.push_back('{rd, 1'b0, acc + LAT});
    endtask

    task automatic drive_d(input logic [31:0] addr, input logic [1:0] sel, input logic re,
                           input logic we, input logic [31:0] wd);
        bit seen = 0;
        dmem_addr = addr; dmem_input_sel = sel; dmem_data_out = wd;
        dmem_re = re; dmem_we = we;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            seen = dmem_done;
        end
        dmem_re = 1'b0; dmem_we = 1'b0;
        if (!seen) begin failed++; tests++; $display("FAIL dmem_timeout @%0t: no done", $time); end
    endtask

    task automatic drive_i(input logic [31:0] addr);
        bit seen = 0;
        imem_addr = addr; imem_re = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            seen = imem_done;
        end
        imem_re = 1'b0;
        if (!seen) begin failed++; tests++; $display("FAIL imem_timeout @%0t: no done", $time); end
    endtask

    task automatic dtxn(input logic [31:0] addr, input logic [1:0] sel, input logic re, input logic we,
                        input logic [3:0] be, input logic [31:0] wd, input logic [31:0] wrep,
                        input logic [31:0] rd);
        @(negedge clock);
        push_d(addr, sel, we, be, wrep, rd, pe + 1);
        drive_d(addr, sel, re, we, wd);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_imem_done"}, 32'(imem_done), 32'h0);
        check({tag, "_dmem_done"}, 32'(dmem_done), 32'h0);
        check({tag, "_exc"}, 32'(dmem_alignment_exception), 32'h0);
        check({tag, "_mem_en"}, 32'(mem_en), 32'h0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        check({tag, "_mem_be"}, 32'(mem_be), 32'h0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_imem_data"}, imem_data_in, 32'h0);
        check({tag, "_dmem_data"}, dmem_data_in, 32'h0);
    endtask

    initial begin
        int a;
        repeat (3) @(negedge clock);
        preload = 1'b0;
        reset_checks("rst");
        reset = 1'b0;

        //   addr      sel  re we  be      wd            wrep          rd
        dtxn(32'h10, 2'd2, 1, 0, 4'hF, 32'h0,        32'h0,        32'hDEADBEEF);
        dtxn(32'h13, 2'd0, 0, 1, 4'h1, 32'h000000A5, 32'hA5A5A5A5, 32'h0);
        dtxn(32'h13, 2'd0, 1, 0, 4'h0, 32'h0,        32'h0,        32'h000000A5);
        dtxn(32'h10, 2'd0, 1, 0, 4'h0, 32'h0,        32'h0,        32'h000000DE);
        dtxn(32'h12, 2'd1, 1, 0, 4'h0, 32'h0,        32'h0,        32'h0000BEA5);
        dtxn(32'h22, 2'd1, 0, 1, 4'h3, 32'hABCD1234, 32'h12341234, 32'h0);
        dtxn(32'h21, 2'd0, 0, 1, 4'h4, 32'hFFFFFF7F, 32'h7F7F7F7F, 32'h0);
        dtxn(32'h20, 2'd3, 1, 0, 4'h0, 32'h0,        32'h0,        32'h017F1234);
        dtxn(32'h30, 2'd2, 0, 1, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0);
        dtxn(32'h34, 2'd2, 1, 1, 4'hF, 32'h11111111, 32'h11111111, 32'h0);
        dtxn(32'h34, 2'd1, 1, 0, 4'h0, 32'h0,        32'h0,        32'h00001111);
        dtxn(32'h21, 2'd1, 1, 0, 4'h0, 32'h0,        32'h0,        32'h0);
        dtxn(32'h22, 2'd2, 0, 1, 4'h0, 32'hFFFFFFFF, 32'h0,        32'h0);
        dtxn(32'h22, 2'd0, 1, 0, 4'h0, 32'h0,        32'h0,        32'h00000012);

        @(negedge clock);
        push_i(32'h10, 32'hDEADBEA5, pe + 1);
        drive_i(32'h10);

        // imem was granted last, so dmem wins the tie.
        @(negedge clock);
        a = pe + 1;
        push_d(32'h30, 2'd2, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D, a);
        push_i(32'h20, 32'h017F1234, a + LAT + 2);
        fork
            drive_d(32'h30, 2'd2, 1'b1, 1'b0, 32'h0);
            drive_i(32'h20);
        join

        // dmem granted last, so imem wins the tie.
        dtxn(32'h10, 2'd2, 1, 0, 4'h0, 32'h0, 32'h0, 32'hDEADBEA5);
        @(negedge clock);
        a = pe + 1;
        push_i(32'h34, 32'h11111111, a);
        push_d(32'h30, 2'd1, 1'b0, 4'h0, 32'h0, 32'h0000CAFE, a + LAT + 2);
        fork
            drive_d(32'h30, 2'd1, 1'b1, 1'b0, 32'h0);
            drive_i(32'h34);
        join

        // Reset while in WAIT: the aborted read must produce no done pulse.
        @(negedge clock);
        sq.push_back('{1'b0, 4'h0, 12'h00C, 32'h0, pe + 1});
        dmem_addr = 32'h30; dmem_input_sel = 2'd2; dmem_re = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        reset_checks("midrst");
        dmem_re = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        last_d = '0;

        // After reset dmem has priority again.
        @(negedge clock);
        a = pe + 1;
        push_d(32'h30, 2'd2, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D, a);
        push_i(32'h10, 32'hDEADBEA5, a + LAT + 2);
        fork
            drive_d(32'h30, 2'd2, 1'b1, 1'b0, 32'h0);
            drive_i(32'h10);
        join

        repeat (10) @(negedge clock);
        check("sram_queue_left", sq.size(), 0);
        check("dmem_queue_left", dq.size(), 0);
        check("imem_queue_left", iq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
